// File: rtl/fetch.sv
// fetch: instruction fetch stage feeding the control decoder.
// Keeps the PC and issues word requests to instruction memory over a
// valid/ready channel. Memory answers in order. Returned words are queued
// together with their PCs, and the head entry is presented to decode.
// A taken jump/branch redirects the PC, flushes the queue and discards
// responses that are still in flight.
// Optional build macro: FETCH_MISALIGN_TRAP_EN. When defined, a misaligned
// jump target raises a sticky flag and halts issue. When undefined, the
// target is word-aligned on redirect and misaligned stays 0.

typedef logic [6:0] opcode_t;
typedef logic [2:0] funct3_t;
typedef logic [6:0] funct7_t;

module fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output opcode_t     opcode,
    output funct3_t     funct3,
    output funct7_t     funct7,
    output logic        misaligned
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      pc;
    logic [31:0]      slot_pc   [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [AW-1:0]    rd_ptr, wr_ptr, fill_ptr;
    logic [CW-1:0]    alloc_cnt, pend_cnt, drop_cnt;
    logic [CW-1:0]    credit_used;
    logic [31:0]      redirect_pc;
    logic             halted;
    logic             consume, xfer, resp_keep;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q;

    assign redirect_pc = target;
    assign halted      = mis_q;
    assign misaligned  = mis_q;

    // Sticky misaligned flag: set by a jump to an unaligned target, cleared by reset or an aligned jump
    always_ff @(posedge clk) begin
        if (reset)
            mis_q <= 1'b0;
        else if (jump)
            mis_q <= |target[1:0];
    end
`else
    assign redirect_pc = target & 32'hFFFF_FFFC;
    assign halted      = 1'b0;
    assign misaligned  = 1'b0;
`endif

    // Head presentation, credit check and handshake decode
    always_comb begin
        ir_valid    = slot_filled[rd_ptr];
        ir          = ir_valid ? slot_data[rd_ptr] : NOP;
        ir_pc       = ir_valid ? slot_pc[rd_ptr] : 32'h0;
        opcode      = ir[6:0];
        funct3      = ir[14:12];
        funct7      = ir[31:25];
        consume     = ir_valid && !stall;
        // A slot freed by this cycle's consume may be reissued at once. Discarded
        // in-flight responses still hold credit until they return.
        credit_used = alloc_cnt - CW'(consume) + drop_cnt;
        imem_req    = !reset && !halted && (credit_used < CW'(DEPTH));
        imem_addr   = pc;
        xfer        = imem_req && imem_ready;
        resp_keep   = imem_rvalid && (drop_cnt == '0);
    end

    // Queue control, PC and discard counter; a jump overrides every other update
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_ADDR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            drop_cnt    <= '0;
            slot_filled <= '0;
        end else if (jump) begin
            pc          <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            slot_filled <= '0;
            // Every outstanding request becomes a discard. This includes one that
            // transfers now. A response arriving in this cycle is dropped here.
            drop_cnt    <= drop_cnt + pend_cnt + CW'(xfer) - CW'(imem_rvalid);
        end else begin
            if (consume) begin
                slot_filled[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            if (imem_rvalid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end else begin
                    slot_filled[fill_ptr] <= 1'b1;
                    fill_ptr              <= fill_ptr + 1'b1;
                end
            end
            if (xfer) begin
                slot_filled[wr_ptr] <= 1'b0;
                wr_ptr              <= wr_ptr + 1'b1;
                pc                  <= pc + 32'd4;
            end
            alloc_cnt <= alloc_cnt + CW'(xfer) - CW'(consume);
            pend_cnt  <= pend_cnt + CW'(xfer) - CW'(resp_keep);
        end
    end

    // Slot payload (PC at issue, word at response); validity lives in slot_filled
    always_ff @(posedge clk) begin
        if (xfer && !jump)
            slot_pc[wr_ptr] <= pc;
        if (resp_keep && !jump)
            slot_data[fill_ptr] <= imem_rdata;
    end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: drives fetch with a reset-aware in-order memory of variable
// latency. A queue-based reference model predicts the outputs every cycle.
module tb_fetch;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          DEPTH      = 2;

    logic        clk = 1'b0;
    logic        reset, stall, jump;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir, ir_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        misaligned;

    always #5 clk = ~clk;

    fetch #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .misaligned(misaligned)
    );

    typedef struct { logic [31:0] pc; bit filled; } entry_t;
    typedef struct { logic [31:0] addr; int due; } mresp_t;

    entry_t      q[$];
    mresp_t      mq[$];
    int          m_drop;
    logic [31:0] m_pc;
    bit          m_mis;
    int          cyc, lat, last_due;
    int          checks, errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    function automatic bit resp_due();
        return (mq.size() > 0) && (mq[0].due <= cyc);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mq.delete();
        m_drop   = 0;
        m_pc     = RESET_ADDR;
        m_mis    = 1'b0;
        last_due = 0;
    endtask

    // One clock cycle: present memory response, check outputs, advance model at the edge.
    task automatic cycle();
        bit          rv, exp_valid, cons, exp_req, x_model, x_mem;
        logic [31:0] exp_ir, exp_pc, hold_addr;
        int          pend, due;
        rv          = resp_due();
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mq[0].addr) : $urandom();
        #1;
        exp_valid = (q.size() > 0) && q[0].filled;
        exp_ir    = exp_valid ? mem_word(q[0].pc) : 32'h0000_0013;
        exp_pc    = exp_valid ? q[0].pc : 32'h0;
        cons      = exp_valid && !stall;
        exp_req   = !reset && !m_mis && ((q.size() - (cons ? 1 : 0) + m_drop) < DEPTH);
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, exp_valid});
        chk("ir", ir, exp_ir);
        chk("ir_pc", ir_pc, exp_pc);
        chk("opcode", {25'b0, opcode}, {25'b0, exp_ir[6:0]});
        chk("funct3", {29'b0, funct3}, {29'b0, exp_ir[14:12]});
        chk("funct7", {25'b0, funct7}, {25'b0, exp_ir[31:25]});
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
        x_model   = exp_req && imem_ready;
        x_mem     = imem_req && imem_ready;
        hold_addr = imem_addr;
        @(posedge clk);
        // memory environment
        if (reset) begin
            mq.delete();
            last_due = 0;
        end else begin
            if (rv) void'(mq.pop_front());
            if (x_mem) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: hold_addr, due: due});
            end
        end
        // reference model
        if (reset) begin
            q.delete();
            m_drop = 0;
            m_pc   = RESET_ADDR;
            m_mis  = 1'b0;
        end else if (jump) begin
            pend = 0;
            foreach (q[i]) if (!q[i].filled) pend++;
            m_drop = m_drop + pend + (x_model ? 1 : 0) - (rv ? 1 : 0);
            q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc  = target;
            m_mis = (target[1:0] != 2'b00);
`else
            m_pc  = target & 32'hFFFF_FFFC;
`endif
        end else begin
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else begin
                    for (int i = 0; i < q.size(); i++)
                        if (!q[i].filled) begin q[i].filled = 1'b1; break; end
                end
            end
            if (cons) void'(q.pop_front());
            if (x_model) begin
                q.push_back('{pc: m_pc, filled: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        checks = 0; errors = 0; cyc = 0; lat = 1;
        reset = 1'b1; stall = 1'b0; jump = 1'b0; target = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // 1: reset, zero-wait memory, latency 1
        cycle();
        reset = 1'b0;
        chk("t1_first_addr", imem_addr, RESET_ADDR);
        repeat (8) cycle();

        // 2: stall for 5 cycles, then resume
        stall = 1'b1;
        repeat (5) cycle();
        stall = 1'b0;
        repeat (6) cycle();

        // 3: latency 3, two requests in flight, jump to 0x100
        reset = 1'b1; lat = 3;
        cycle();
        reset = 1'b0;
        repeat (2) cycle();
        jump = 1'b1; target = 32'h100;
        cycle();
        jump = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (ir_valid === 1'b1) seen = 1'b1;
        end
        chk("t3_seen", {31'b0, seen}, 32'h1);
        chk("t3_pc", ir_pc, 32'h100);
        chk("t3_ir", ir, mem_word(32'h100));
        repeat (4) cycle();

        // 4: jump coincident with a response while stalled
        lat = 2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (resp_due()) seen = 1'b1;
            else cycle();
        end
        chk("t4_resp_due", {31'b0, seen}, 32'h1);
        stall = 1'b1; jump = 1'b1; target = 32'h300;
        cycle();
        jump = 1'b0;
        chk("t4_empty", {31'b0, ir_valid}, 32'h0);
        chk("t4_addr", imem_addr, 32'h300);
        stall = 1'b0;
        repeat (8) cycle();

        // 5: reset with two slots filled
        lat = 1; stall = 1'b1;
        repeat (4) cycle();
        chk("t5_full", {31'b0, ir_valid}, 32'h1);
        reset = 1'b1;
        cycle();
        chk("t5_valid", {31'b0, ir_valid}, 32'h0);
        chk("t5_nop", ir, 32'h0000_0013);
        reset = 1'b0; stall = 1'b0;
        chk("t5_addr", imem_addr, RESET_ADDR);
        repeat (4) cycle();

        // 6: misaligned jump target
        jump = 1'b1; target = 32'h102;
        cycle();
        jump = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_mis", {31'b0, misaligned}, 32'h1);
        repeat (4) cycle();
        chk("t6_halt", {31'b0, imem_req}, 32'h0);
        jump = 1'b1; target = 32'h200;
        cycle();
        jump = 1'b0;
        chk("t6_clear", {31'b0, misaligned}, 32'h0);
`else
        chk("t6_addr", imem_addr, 32'h100);
`endif
        repeat (6) cycle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 31) == 0) lat = $urandom_range(1, 4);
            stall      = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            jump       = ($urandom_range(0, 15) == 0);
            target     = $urandom() & 32'h0000_FFFC;
            if ($urandom_range(0, 3) == 0) target[1:0] = 2'($urandom_range(1, 3));
            reset      = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0; jump = 1'b0; stall = 1'b0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
Instruction fetch stage. It sits directly upstream of the control decoder and keeps the PC, issuing word requests to instruction memory over a valid/ready request channel with an in-order response channel. Returned words are buffered with their PCs in a small queue. The head entry is presented to decode, split into opcode/funct3/funct7. On a taken jump/branch the PC is redirected, the queue is flushed, and in-flight responses are discarded.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset (word aligned).
DEPTH, 2, number of queue slots, and therefore the maximum number of outstanding plus buffered fetches (power of two, >= 2).

Ports:
clk  input  1  clock; one clock for the whole block
reset  input  1  synchronous, active-high reset
stall  input  1  decode not accepting this cycle; head entry is held
jump  input  1  redirect request, taken jump/branch from execute
target  input  32  redirect PC, sampled when jump=1
imem_req  output  1  request valid
imem_addr  output  32  request word address (byte PC, bits[1:0]=00)
imem_ready  input  1  memory accepts request; transfer when imem_req&&imem_ready
imem_rvalid  input  1  response valid; one per accepted request, in order, latency >= 1 cycle
imem_rdata  input  32  response instruction word
ir_valid  output  1  head entry holds a valid instruction
ir  output  32  head instruction; 32'h0000_0013 (NOP) when ir_valid=0
ir_pc  output  32  PC of head instruction; 0 when ir_valid=0
opcode  output  7  ir[6:0] typed opcode_t
funct3  output  3  ir[14:12] typed funct3_t
funct7  output  7  ir[31:25] typed funct7_t
misaligned  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Reset, synchronous and active-high, applies on the next clk edge. After reset: pc=RESET_ADDR, queue empty, all counters 0, imem_req=0 during the reset cycle, ir_valid=0, ir=NOP, ir_pc=0, misaligned=0. Instruction memory shares this reset, so no response arrives for requests issued before reset.
- Queue slots are allocated at issue. The slot records the PC and is marked pending; it is marked filled when the response arrives. Head = oldest slot. ir_valid = head filled.
- imem_req=1 when there is a free slot (allocated < DEPTH), no reset, and fetching is not halted. imem_addr=pc.
- On a transfer: allocate slot {pc, pending}, then pc <= pc+4 (wraps modulo 2^32).
- Response: write imem_rdata into the oldest pending slot. Responses are strictly in order.
- Consume: when ir_valid && !stall, the head is freed. A freed slot is reusable in the same cycle. With zero-wait memory this gives 1 instruction/cycle throughput.
- stall with ir_valid=0: no effect. stall never blocks issue or response capture.
- Jump has priority over everything else in the cycle:
  - All slots are freed.
  - drop <= number of pending slots, counting any transfer in the same cycle.
  - pc <= target.
  - Any response arriving in the jump cycle is discarded.
  - Issue to target may begin the next cycle.
- While drop>0, each imem_rvalid decrements drop and is discarded. Those responses still occupy credit, so allocated + drop <= DEPTH is the issue condition.
- Jump in the same cycle as a consume: the consume is ignored because the queue is flushed anyway.
- Outputs opcode/funct3/funct7/ir/ir_pc are combinational from the head slot; there is no extra register stage.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a jump with target[1:0]!=0 sets misaligned=1, performs the flush, and halts issue (imem_req=0). misaligned clears, and issue resumes, only on reset or on a later jump with an aligned target.
- Not defined: target[1:0] is forced to 00 on redirect, and misaligned is tied to 0.

Test Plan:
1. Reset with imem_ready=1 and latency 1 -> first transfer at addr 0x0, then 0x4, 0x8. ir_valid rises 2 cycles after reset deasserts; one instruction per cycle thereafter with ir_pc 0x0, 0x4, 0x8.
2. Hold stall=1 for 5 cycles with DEPTH=2 -> imem_req drops after 2 allocations. ir/ir_pc are held at the same values. After stall=0, the sequence resumes with no skipped or duplicated PC.
3. Memory latency 3 with 2 requests in flight, then jump with target=0x100 -> the 2 stale responses are discarded. The next ir_valid shows ir_pc=0x100 with the 0x100 word.
4. Jump in the same cycle as imem_rvalid, with stall=1 -> that response is dropped, the queue is empty next cycle, and imem_addr=target.
5. Assert reset mid-stream with 2 slots filled -> next cycle ir_valid=0, ir=32'h13, imem_addr=RESET_ADDR after release.
6. Jump with target=0x102 -> with FETCH_MISALIGN_TRAP_EN: misaligned=1 and imem_req=0 until jump to 0x200. Without the macro: the fetch address is 0x100.
